// File: rtl/svd_host_if.sv
// ---------------------------------------------------------------------------
// svd_host_if
//
// Host-side load/unload interface for the 2x2 CORDIC SVD core.
//
// Load: the host streams each matrix element A[0..3] in CHUNK_W-wide pieces,
// LSB chunk first. Once all four elements are complete, a falling edge on
// "we" fires a one-cycle start pulse to the core.
//
// Unload: when the core reports done, U, V and the singular values are
// latched. The host then reads them back one element per selection. The
// U/V word alternates U, V, U, ... while the selection stays the same.
//
// Optional feature (macro SVD_IF_ERR_EN):
//   defined   -> err is a sticky protocol-error flag, cleared only by rst
//   undefined -> err is tied to 0; the datapath behaves identically
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   we, oe          host write enable / output enable
//   data_i          host data chunk (CHUNK_W)
//   element_sel     element index: 0=(0,0) 1=(0,1) 2=(1,0) 3=(1,1)
//   ready           results latched and readable
//   data_o_UV       U or V element being served (UV_W)
//   data_o_S        singular value on diagonal selections (S_W)
//   err             sticky protocol error
//   core_a_o        assembled matrix, element 0 in the LSBs
//   core_start_o    one-cycle start pulse to the core
//   core_done_i     one-cycle completion pulse from the core
//   core_u_i/v_i    U and V matrices, element 0 in the LSBs
//   core_s_i        sigma1 in the LSBs, sigma2 above it
// ---------------------------------------------------------------------------
module svd_host_if #(
  parameter int ELEM_W  = 10,
  parameter int CHUNK_W = 5,
  parameter int UV_W    = 8,
  parameter int S_W     = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                oe,
  input  logic [CHUNK_W-1:0]  data_i,
  input  logic [1:0]          element_sel,
  output logic                ready,
  output logic [UV_W-1:0]     data_o_UV,
  output logic [S_W-1:0]      data_o_S,
  output logic                err,
  output logic [4*ELEM_W-1:0] core_a_o,
  output logic                core_start_o,
  input  logic                core_done_i,
  input  logic [4*UV_W-1:0]   core_u_i,
  input  logic [4*UV_W-1:0]   core_v_i,
  input  logic [2*S_W-1:0]    core_s_i
);

  localparam int CH    = ELEM_W / CHUNK_W;
  // The counter must be able to hold CH itself, which marks "element full,
  // further chunks are ignored".
  localparam int CNT_W = $clog2(CH + 1);
  localparam logic [CNT_W-1:0] CH_LAST = CNT_W'(CH - 1);
  localparam logic [CNT_W-1:0] CH_FULL = CNT_W'(CH);

  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

  state_t            state;
  logic [ELEM_W-1:0] elem  [4];
  logic [UV_W-1:0]   u_lat [4];
  logic [UV_W-1:0]   v_lat [4];
  logic [S_W-1:0]    s1_lat;
  logic [S_W-1:0]    s2_lat;
  logic [3:0]        mask;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [1:0]        sel_q;
  logic              phase;
  logic              serving_q;

  logic              sel_changed;
  logic [CNT_W-1:0]  chunk_idx;
  logic              chunk_ok;
  logic              phase_use;
  logic [UV_W-1:0]   u_sel;
  logic [UV_W-1:0]   v_sel;
  logic [S_W-1:0]    s_sel;

  // A fresh write burst (we rising or a new selection) restarts at chunk 0.
  assign sel_changed = (element_sel != sel_q);
  assign chunk_idx   = (!we_q || sel_changed) ? '0 : cnt;
  assign chunk_ok    = (chunk_idx < CH_FULL);

  // The phase alternates only across back-to-back reads of the same
  // element; any gap in serving or a new selection restarts with U.
  assign phase_use = serving_q && !sel_changed && !phase;

  assign u_sel = u_lat[element_sel];
  assign v_sel = v_lat[element_sel];
  assign s_sel = (element_sel == 2'd0) ? s1_lat :
                 (element_sel == 2'd3) ? s2_lat : '0;

  assign core_a_o = {elem[3], elem[2], elem[1], elem[0]};

  // Main control FSM: chunk assembly in LOAD, waiting for the core in RUN,
  // serving results (or restarting a load) in DONE. All outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD;
      mask         <= '0;
      cnt          <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      phase        <= 1'b0;
      serving_q    <= 1'b0;
      ready        <= 1'b0;
      data_o_UV    <= '0;
      data_o_S     <= '0;
      core_start_o <= 1'b0;
      s1_lat       <= '0;
      s2_lat       <= '0;
      for (int i = 0; i < 4; i++) begin
        elem[i]  <= '0;
        u_lat[i] <= '0;
        v_lat[i] <= '0;
      end
    end else begin
      we_q         <= we;
      sel_q        <= element_sel;
      core_start_o <= 1'b0;
      data_o_UV    <= '0;
      data_o_S     <= '0;
      serving_q    <= 1'b0;

      case (state)
        LOAD: begin
          if (we) begin
            if (chunk_ok) begin
              for (int c = 0; c < CH; c++) begin
                if (chunk_idx == CNT_W'(c))
                  elem[element_sel][c*CHUNK_W +: CHUNK_W] <= data_i;
              end
              cnt <= chunk_idx + CNT_W'(1);
              if (chunk_idx == CH_LAST)
                mask[element_sel] <= 1'b1;
            end
          end else if (we_q && (mask == 4'hF)) begin
            core_start_o <= 1'b1;
            ready        <= 1'b0;
            state        <= RUN;
          end
        end

        RUN: begin
          if (core_done_i) begin
            for (int i = 0; i < 4; i++) begin
              u_lat[i] <= core_u_i[i*UV_W +: UV_W];
              v_lat[i] <= core_v_i[i*UV_W +: UV_W];
            end
            s1_lat <= core_s_i[S_W-1:0];
            s2_lat <= core_s_i[2*S_W-1:S_W];
            ready  <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          if (we) begin
            // Restart: this cycle's chunk is already chunk 0 of the new load.
            state <= LOAD;
            ready <= 1'b0;
            mask  <= '0;
            if (CH == 1)
              mask[element_sel] <= 1'b1;
            elem[element_sel][CHUNK_W-1:0] <= data_i;
            cnt   <= CNT_W'(1);
          end else if (oe) begin
            serving_q <= 1'b1;
            phase     <= phase_use;
            data_o_UV <= phase_use ? v_sel : u_sel;
            data_o_S  <= s_sel;
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

`ifdef SVD_IF_ERR_EN
  logic err_q;

  // Sticky protocol-error flag; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if ((state == RUN && we) ||
             (state == LOAD && we && !chunk_ok) ||
             (oe && !ready) ||
             (core_done_i && state != RUN))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_svd_host_if.sv
// ---------------------------------------------------------------------------
// tb_svd_host_if
//
// Self-checking bench for svd_host_if with default parameters. A behavioural
// model (element values as integers, counts of consecutive writes/reads)
// predicts every registered output each cycle. Directed table vectors and
// hand sequences cover the documented load/unload scenarios; a randomized
// phase follows.
// ---------------------------------------------------------------------------
module tb_svd_host_if;

  localparam int ELEM_W  = 10;
  localparam int CHUNK_W = 5;
  localparam int UV_W    = 8;
  localparam int S_W     = 7;
  localparam int CH      = ELEM_W / CHUNK_W;

  localparam int M_LOAD = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic                clk;
  logic                rst;
  logic                we;
  logic                oe;
  logic [CHUNK_W-1:0]  data_i;
  logic [1:0]          element_sel;
  logic                ready;
  logic [UV_W-1:0]     data_o_UV;
  logic [S_W-1:0]      data_o_S;
  logic                err;
  logic [4*ELEM_W-1:0] core_a_o;
  logic                core_start_o;
  logic                core_done_i;
  logic [4*UV_W-1:0]   core_u_i;
  logic [4*UV_W-1:0]   core_v_i;
  logic [2*S_W-1:0]    core_s_i;

  svd_host_if #(
    .ELEM_W (ELEM_W),
    .CHUNK_W(CHUNK_W),
    .UV_W   (UV_W),
    .S_W    (S_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .oe          (oe),
    .data_i      (data_i),
    .element_sel (element_sel),
    .ready       (ready),
    .data_o_UV   (data_o_UV),
    .data_o_S    (data_o_S),
    .err         (err),
    .core_a_o    (core_a_o),
    .core_start_o(core_start_o),
    .core_done_i (core_done_i),
    .core_u_i    (core_u_i),
    .core_v_i    (core_v_i),
    .core_s_i    (core_s_i)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount;
  int failCount;

  // Behavioural model state.
  int          mMode;
  int unsigned mA [4];
  bit          mFull [4];
  int          mPos;
  bit          mPrevWe;
  int          mPrevSel;
  int          mServeRun;
  bit          mReady;
  bit          mStart;
  bit          mErr;
  int unsigned mUv;
  int unsigned mS;
  int unsigned mU [4];
  int unsigned mV [4];
  int unsigned mS1;
  int unsigned mS2;

  typedef struct {
    bit          w;
    int          sel;
    int unsigned d;
    bit          expStart;
    bit          expReady;
  } vec_t;

  vec_t loadVec [10];

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic writeChunk(input int sel, input int p, input int unsigned d);
    int unsigned cm;
    cm = (1 << CHUNK_W) - 1;
    mA[sel] = ((mA[sel] & ~(cm << (p * CHUNK_W))) | ((d & cm) << (p * CHUNK_W)))
              & ((1 << ELEM_W) - 1);
  endtask

  // Predicts the state just after the coming clock edge from this cycle's inputs.
  task automatic modelStep(input bit r, input bit w, input bit o, input int sel,
                           input int unsigned d, input bit dn);
    bit          startN;
    bit          served;
    int unsigned uvN;
    int unsigned sN;
    int          pos;
    bit          allFull;
    startN = 0;
    served = 0;
    uvN    = 0;
    sN     = 0;
    if (r) begin
      mMode = M_LOAD;
      for (int i = 0; i < 4; i++) begin
        mA[i] = 0; mFull[i] = 0; mU[i] = 0; mV[i] = 0;
      end
      mPos = 0; mPrevWe = 0; mPrevSel = 0; mServeRun = -1;
      mReady = 0; mErr = 0; mS1 = 0; mS2 = 0;
    end else begin
      pos = (w && mPrevWe && sel == mPrevSel) ? mPos + 1 : 0;
      allFull = mFull[0] && mFull[1] && mFull[2] && mFull[3];
`ifdef SVD_IF_ERR_EN
      if ((mMode == M_RUN && w) || (mMode == M_LOAD && w && pos >= CH) ||
          (o && !mReady) || (dn && mMode != M_RUN))
        mErr = 1;
`endif
      if (mMode == M_LOAD) begin
        if (w) begin
          if (pos < CH) begin
            writeChunk(sel, pos, d);
            if (pos == CH - 1) mFull[sel] = 1;
          end
        end else if (mPrevWe && allFull) begin
          startN = 1;
          mReady = 0;
          mMode  = M_RUN;
        end
      end else if (mMode == M_RUN) begin
        if (dn) begin
          for (int i = 0; i < 4; i++) begin
            mU[i] = (core_u_i >> (i * UV_W)) & ((1 << UV_W) - 1);
            mV[i] = (core_v_i >> (i * UV_W)) & ((1 << UV_W) - 1);
          end
          mS1 = core_s_i & ((1 << S_W) - 1);
          mS2 = (core_s_i >> S_W) & ((1 << S_W) - 1);
          mReady = 1;
          mMode  = M_DONE;
        end
      end else begin
        if (w) begin
          for (int i = 0; i < 4; i++) mFull[i] = 0;
          mReady = 0;
          mMode  = M_LOAD;
          pos    = 0;
          writeChunk(sel, 0, d);
          if (CH == 1) mFull[sel] = 1;
        end else if (o) begin
          if (mServeRun >= 0 && sel == mPrevSel) mServeRun++;
          else mServeRun = 0;
          served = 1;
          uvN = (mServeRun % 2 == 1) ? mV[sel] : mU[sel];
          sN  = (sel == 0) ? mS1 : (sel == 3) ? mS2 : 0;
        end
      end
      if (!served) mServeRun = -1;
      mPos = pos;
      mPrevWe = w;
      mPrevSel = sel;
    end
    mStart = startN;
    mUv = uvN;
    mS = sN;
  endtask

  // Compares every DUT output with the model.
  task automatic checkOutput();
    logic [63:0] expA;
    expA = '0;
    for (int i = 0; i < 4; i++) expA[i*ELEM_W +: ELEM_W] = ELEM_W'(mA[i]);
    checkVal("ready", {63'd0, ready}, {63'd0, mReady});
    checkVal("start", {63'd0, core_start_o}, {63'd0, mStart});
    checkVal("err", {63'd0, err}, {63'd0, mErr});
    checkVal("data_o_UV", 64'(data_o_UV), 64'(mUv));
    checkVal("data_o_S", 64'(data_o_S), 64'(mS));
    checkVal("core_a_o", 64'(core_a_o), expA);
  endtask

  // Drives one cycle of inputs, advances the model, samples 1 unit after the edge.
  task automatic applyStimulus(input bit r, input bit w, input bit o, input int sel,
                               input int unsigned d, input bit dn);
    rst = r; we = w; oe = o; element_sel = 2'(sel);
    data_i = CHUNK_W'(d); core_done_i = dn;
    modelStep(r, w, o, sel, d, dn);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic loadElem(input int sel, input int unsigned c0, input int unsigned c1);
    applyStimulus(0, 1, 0, sel, c0, 0);
    applyStimulus(0, 1, 0, sel, c1, 0);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst = 1; we = 0; oe = 0; data_i = '0; element_sel = '0; core_done_i = 0;
    core_u_i = '0; core_v_i = '0; core_s_i = '0;

    loadVec[0] = '{1, 0, 5'b01011, 0, 0};
    loadVec[1] = '{1, 0, 5'b00001, 0, 0};
    loadVec[2] = '{1, 1, 5'b00001, 0, 0};
    loadVec[3] = '{1, 1, 5'b11111, 0, 0};
    loadVec[4] = '{1, 2, 5'b01000, 0, 0};
    loadVec[5] = '{1, 2, 5'b11110, 0, 0};
    loadVec[6] = '{1, 3, 5'b00100, 0, 0};
    loadVec[7] = '{1, 3, 5'b11111, 0, 0};
    loadVec[8] = '{0, 0, 0, 1, 0};
    loadVec[9] = '{0, 0, 0, 0, 0};

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkVal("rst_ready", {63'd0, ready}, 64'd0);
    checkVal("rst_core_a", 64'(core_a_o), 64'd0);
    checkVal("rst_uv", 64'(data_o_UV), 64'd0);

    $display("[TB] table-driven load");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, loadVec[i].w, 0, loadVec[i].sel, loadVec[i].d, 0);
      checkVal("vec_start", {63'd0, core_start_o}, {63'd0, loadVec[i].expStart});
      checkVal("vec_ready", {63'd0, ready}, {63'd0, loadVec[i].expReady});
    end
    checkVal("plan_core_a", 64'(core_a_o), 64'({10'h3E4, 10'h3C8, 10'h3E1, 10'h02B}));

    $display("[TB] core completion and unload");
    core_u_i = {8'h11, 8'h22, 8'h33, 8'h5A};
    core_v_i = {8'h44, 8'h55, 8'h66, 8'hA5};
    core_s_i = {7'h15, 7'h3C};
    repeat (38) applyStimulus(0, 0, 0, 0, 0, 0);
    checkVal("run_ready", {63'd0, ready}, 64'd0);
    checkVal("run_core_a", 64'(core_a_o), 64'({10'h3E4, 10'h3C8, 10'h3E1, 10'h02B}));
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkVal("done_ready", {63'd0, ready}, 64'd1);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkVal("uv_0", 64'(data_o_UV), 64'h5A);
    checkVal("s_0", 64'(data_o_S), 64'h3C);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkVal("uv_1", 64'(data_o_UV), 64'hA5);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkVal("uv_2", 64'(data_o_UV), 64'h5A);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkVal("uv_sel1", 64'(data_o_UV), 64'h33);
    checkVal("s_sel1", 64'(data_o_S), 64'h0);
    applyStimulus(0, 0, 1, 3, 0, 0);
    checkVal("s_sel3", 64'(data_o_S), 64'h15);
    applyStimulus(0, 0, 0, 3, 0, 0);
    checkVal("uv_oe_off", 64'(data_o_UV), 64'h0);

    $display("[TB] restart from DONE");
    applyStimulus(0, 1, 0, 0, 1, 0);
    checkVal("restart_ready", {63'd0, ready}, 64'd0);
    applyStimulus(0, 1, 0, 0, 16, 0);
    for (int s = 1; s < 4; s++) loadElem(s, s + 1, 16 + s);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkVal("restart_start", {63'd0, core_start_o}, 64'd1);
    checkVal("restart_core_a", 64'(core_a_o), 64'({10'h264, 10'h243, 10'h222, 10'h201}));

    $display("[TB] reset during RUN");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkVal("rstrun_ready", {63'd0, ready}, 64'd0);
    checkVal("rstrun_core_a", 64'(core_a_o), 64'd0);
    loadElem(3, 4, 31);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkVal("rstrun_nostart", {63'd0, core_start_o}, 64'd0);

    $display("[TB] incomplete mask");
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int s = 0; s < 3; s++) loadElem(s, 7 + s, 2);
    repeat (3) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkVal("partial_nostart", {63'd0, core_start_o}, 64'd0);
    end
    loadElem(3, 9, 9);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkVal("partial_start", {63'd0, core_start_o}, 64'd1);

    $display("[TB] extra chunk");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 5'h03, 0);
    applyStimulus(0, 1, 0, 0, 5'h1C, 0);
    applyStimulus(0, 1, 0, 0, 5'h0F, 0);
    checkVal("extra_elem0", 64'(core_a_o[ELEM_W-1:0]), 64'h383);
`ifdef SVD_IF_ERR_EN
    checkVal("extra_err", {63'd0, err}, 64'd1);
`else
    checkVal("extra_err", {63'd0, err}, 64'd0);
`endif
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkVal("extra_err_rst", {63'd0, err}, 64'd0);

    $display("[TB] randomized phase");
    begin
      bit rw;
      bit ro;
      int rs;
      rw = 0; ro = 0; rs = 0;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 5) == 0) rw = ~rw;
        if ($urandom_range(0, 3) == 0) ro = ~ro;
        if ($urandom_range(0, 3) == 0) rs = int'($urandom_range(0, 3));
        core_u_i = $urandom;
        core_v_i = $urandom;
        core_s_i = 14'($urandom);
        applyStimulus($urandom_range(0, 299) == 0, rw, ro, rs,
                      $urandom_range(0, 31), $urandom_range(0, 24) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/svd_host_if.md
Name: svd_host_if

Overview:
- Parametrised host-side load/unload interface for the 2x2 CORDIC SVD core.
- Load path: accepts matrix elements A[0..3] over a narrow chunked bus, assembles each into a full-width element and hands all four to the core with a single start pulse.
- Unload path: latches U, V and singular values S when the core signals done, then serves them to the host, one element per selection.
- Generalises element width, chunk width and output widths; adds per-element completion tracking, restart and error reporting.

Parameters:
- ELEM_W, 10: input matrix element width (two's complement, fixed point).
- CHUNK_W, 5: host input chunk width; ELEM_W must be an integer multiple of CHUNK_W; CH = ELEM_W/CHUNK_W.
- UV_W, 8: width of each U/V element returned by the core.
- S_W, 7: width of each singular value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- we  in  1  host write enable (load chunks).
- oe  in  1  host output enable.
- data_i  in  CHUNK_W  host data chunk.
- element_sel  in  2  element index: 0=(0,0), 1=(0,1), 2=(1,0), 3=(1,1).
- ready  out  1  results valid and readable.
- data_o_UV  out  UV_W  U or V element currently being served.
- data_o_S  out  S_W  singular value on the diagonal selections.
- err  out  1  sticky protocol error (see Optional Feature).
- core_a_o  out  4*ELEM_W  assembled matrix, element 0 in the LSBs.
- core_start_o  out  1  one-cycle start pulse to the core.
- core_done_i  in  1  one-cycle completion pulse from the core.
- core_u_i  in  4*UV_W  U matrix from the core, element 0 in the LSBs.
- core_v_i  in  4*UV_W  V matrix from the core, element 0 in the LSBs.
- core_s_i  in  2*S_W  sigma1 in the LSBs, sigma2 above it.

Behaviour:
- Reset: synchronous, wins over every other input; all outputs, the element registers, the valid mask, the chunk counter and the phase bit clear to 0; state goes to LOAD. Asserting rst mid-RUN abandons the run, and any later core_done_i is ignored.
- States: LOAD, RUN, DONE.
- LOAD, we=1: data_i is written into chunk k of A[element_sel], LSB chunk first.
  - k resets to 0 on a we rising edge or any element_sel change; otherwise k increments each cycle.
  - When chunk CH-1 is written, mask[element_sel] sets.
  - Chunks beyond CH-1 for the same selection are ignored.
  - Re-selecting an element overwrites it from chunk 0.
- LOAD, we falling edge (we previous cycle 1, now 0):
  - mask==4'b1111: core_start_o pulses for exactly one cycle, state goes to RUN, ready=0.
  - mask incomplete: stay in LOAD with the mask preserved.
- core_a_o: driven from the element registers at all times; held stable throughout RUN.
- RUN: we and oe are ignored. On core_done_i, latch core_u_i, core_v_i and core_s_i, set ready=1 and go to DONE.
- DONE, oe=1, output is registered with 1-cycle latency:
  - Phase bit toggles every cycle while element_sel is unchanged and resets to 0 on a sel change or an oe rising edge.
  - phase 0: data_o_UV=U[sel]; phase 1: data_o_UV=V[sel].
  - data_o_S = sigma1 when sel=0, sigma2 when sel=3, else 0.
  - oe=0: outputs hold 0.
- DONE, we=1: restart. Clear mask and ready, go to LOAD, and capture this cycle's chunk as chunk 0. we takes priority over oe in the same cycle.
- oe in LOAD or RUN: outputs remain 0.

Optional Feature:
- Macro: SVD_IF_ERR_EN.
- Defined: err sets (sticky until rst) on any of:
  - we=1 during RUN;
  - a chunk beyond CH-1 for the same selection;
  - oe=1 while ready=0;
  - core_done_i outside RUN.
- Undefined: err is tied to 0; the same events are silently ignored, with identical datapath behaviour either way.

Test Plan:
- Load with default parameters: sel0 chunks 01011,00001 (43); sel1 00001,11111 (-31); sel2 01000,11110 (-56); sel3 00100,11111 (-28); then drop we -> core_a_o = {10'h3E4,10'h3C8,10'h3E1,10'h02B}, core_start_o high for exactly 1 cycle, ready=0.
- Core model pulses core_done_i 40 cycles later with U[0]=8'h5A, V[0]=8'hA5, sigma1=7'h3C -> ready=1. Then oe=1, sel=0 -> data_o_UV 8'h5A, 8'hA5, 8'h5A on successive cycles, data_o_S=7'h3C; sel=1 -> data_o_S=0.
- Load only sel0..sel2, then drop we -> no start pulse, state stays LOAD. Then load sel3 and drop we -> start pulse.
- Assert rst during RUN, then pulse core_done_i -> ready stays 0, all outputs 0, mask 0.
- In DONE, we=1 with new chunks -> ready=0 the next cycle; a new load completes and a new start pulse follows.
- With SVD_IF_ERR_EN defined, write 3 chunks to sel0 -> err=1 and remains 1 until rst; element value equals the first two chunks. With the macro undefined, the same stimulus gives err=0.
